// File: rtl/logic_sweep_ctrl.sv
// logic_sweep_ctrl
//   Drives a shared combinational logic unit either through every input
//   vector (exhaustive sweep) or with one host-supplied vector. After each
//   vector has settled, the unit outputs are folded into a MISR signature
//   and counted per output bit. At completion the signature is compared
//   against an expected value.
//
//   State table
//     state  | meaning
//     IDLE   | waiting for start; accumulators hold the last run's results
//     WAIT   | lu_in stable, counting down the settle time
//     SAMPLE | capture lu_out into sig/ones_cnt, then advance or finish
//     DONE   | one-cycle completion pulse, then back to IDLE
//
// Ports
//   clk       clock, rising edge
//   rst       synchronous reset, active high
//   start     request a run (honoured only in IDLE, lost to abort)
//   abort     cancel a run in progress
//   mode      0 = exhaustive sweep, 1 = single vector (sampled with start)
//   vec_in    single-mode vector (sampled with start)
//   exp_sig   expected signature (sampled at the final sample edge)
//   lu_in     registered vector to the logic unit
//   lu_out    logic unit outputs (bit0 = x, bit1 = y, bit2 = z)
//   busy      high in WAIT and SAMPLE
//   done      one-cycle completion pulse
//   pass      signature match at completion, held until the next start
//   sig       running MISR signature
//   ones_cnt  per-output ones counts, field k = [k*(N_IN+1) +: N_IN+1]
module logic_sweep_ctrl #(
    parameter int N_IN   = 5,
    parameter int N_OUT  = 3,
    parameter int SETTLE = 1,
    parameter int SIG_W  = 16,
    parameter logic [SIG_W-1:0] POLY = 16'h1021
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    input  logic                      mode,
    input  logic [N_IN-1:0]           vec_in,
    input  logic [SIG_W-1:0]          exp_sig,
    output logic [N_IN-1:0]           lu_in,
    input  logic [N_OUT-1:0]          lu_out,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic [SIG_W-1:0]          sig,
    output logic [N_OUT*(N_IN+1)-1:0] ones_cnt
);

    localparam int CNT_W = N_IN + 1;
    localparam int CW    = $clog2(SETTLE + 2);
    // Settle timer is a down-counter; loading SETTLE-1 gives SETTLE cycles in WAIT.
    localparam logic [CW-1:0] SETTLE_LD = (SETTLE > 0) ? CW'(SETTLE - 1) : '0;

    typedef enum logic [1:0] {IDLE, WAIT, SAMPLE, DONE} state_t;

    state_t                     state, state_nxt;
    logic                       mode_r, mode_nxt;
    logic [CW-1:0]              settle_cnt, settle_nxt;
    logic [N_IN-1:0]            lu_in_nxt;
    logic [SIG_W-1:0]           sig_nxt, sig_step;
    logic [N_OUT*CNT_W-1:0]     cnt_nxt, cnt_step;
    logic                       pass_nxt;
    logic                       last_vec;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            mode_r     <= 1'b0;
            settle_cnt <= '0;
            lu_in      <= '0;
            sig        <= '0;
            ones_cnt   <= '0;
            pass       <= 1'b0;
        end else begin
            state      <= state_nxt;
            mode_r     <= mode_nxt;
            settle_cnt <= settle_nxt;
            lu_in      <= lu_in_nxt;
            sig        <= sig_nxt;
            ones_cnt   <= cnt_nxt;
            pass       <= pass_nxt;
        end
    end

    always_comb begin
        sig_step = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ SIG_W'(lu_out);
        cnt_step = ones_cnt;
        for (int k = 0; k < N_OUT; k++) begin
            cnt_step[k*CNT_W +: CNT_W] = ones_cnt[k*CNT_W +: CNT_W] + CNT_W'(lu_out[k]);
        end
    end

    assign last_vec = mode_r || (lu_in == '1);

    always_comb begin
        state_nxt  = state;
        mode_nxt   = mode_r;
        settle_nxt = settle_cnt;
        lu_in_nxt  = lu_in;
        sig_nxt    = sig;
        cnt_nxt    = ones_cnt;
        pass_nxt   = pass;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    sig_nxt    = '0;
                    cnt_nxt    = '0;
                    pass_nxt   = 1'b0;
                    lu_in_nxt  = mode ? vec_in : '0;
                    mode_nxt   = mode;
                    settle_nxt = SETTLE_LD;
                    state_nxt  = (SETTLE == 0) ? SAMPLE : WAIT;
                end
            end
            WAIT: begin
                if (abort)
                    state_nxt = IDLE;
                else if (settle_cnt == '0)
                    state_nxt = SAMPLE;
                else
                    settle_nxt = settle_cnt - CW'(1);
            end
            SAMPLE: begin
                // abort takes priority: the vector in flight is not accumulated
                if (abort) begin
                    state_nxt = IDLE;
                end else begin
                    sig_nxt = sig_step;
                    cnt_nxt = cnt_step;
                    if (last_vec) begin
                        pass_nxt  = (sig_step == exp_sig);
                        state_nxt = DONE;
                    end else begin
                        lu_in_nxt  = lu_in + N_IN'(1);
                        settle_nxt = SETTLE_LD;
                        state_nxt  = (SETTLE == 0) ? SAMPLE : WAIT;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == WAIT) || (state == SAMPLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_logic_sweep_ctrl.sv
module tb_logic_sweep_ctrl;

    localparam int N_IN  = 5;
    localparam int N_OUT = 3;
    localparam int SIG_W = 16;
    localparam int CNT_W = N_IN + 1;
    localparam logic [15:0] POLY = 16'h1021;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     start = 1'b0;
    logic                     abort = 1'b0;
    logic                     mode = 1'b0;
    logic [N_IN-1:0]          vec_in = '0;
    logic [SIG_W-1:0]         exp_sig = '0;
    logic [N_IN-1:0]          lu_in;
    logic [N_OUT-1:0]         lu_out;
    logic                     busy, done, pass;
    logic [SIG_W-1:0]         sig;
    logic [N_OUT*CNT_W-1:0]   ones_cnt;
    logic [1:0]               lu_sel = 2'd0;

    int n_pass = 0;
    int n_checks = 0;

    always #5 clk = ~clk;

    // Reference logic unit: x = (a&b)|c, y = parity(a..e), z = (a|d)&~e
    function automatic logic [2:0] lu_fn(input logic [4:0] v);
        logic a, b, c, d, e;
        {e, d, c, b, a} = v;
        return {(a | d) & ~e, ^v, (a & b) | c};
    endfunction

    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [2:0] o);
        return {s[14:0], 1'b0} ^ (s[15] ? POLY : 16'h0) ^ {13'b0, o};
    endfunction

    assign lu_out = (lu_sel == 2'd0) ? 3'b000 :
                    (lu_sel == 2'd1) ? 3'b001 : lu_fn(lu_in);

    logic_sweep_ctrl #(.N_IN(N_IN), .N_OUT(N_OUT), .SETTLE(1), .SIG_W(SIG_W), .POLY(POLY)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
        .vec_in(vec_in), .exp_sig(exp_sig), .lu_in(lu_in), .lu_out(lu_out),
        .busy(busy), .done(done), .pass(pass), .sig(sig), .ones_cnt(ones_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    function automatic logic [CNT_W-1:0] fld(input int k);
        return ones_cnt[k*CNT_W +: CNT_W];
    endfunction

    task automatic run_to_done(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 200 && !done; i++) tick();
        check(tag, done, 1);
        tick();
    endtask

    initial begin
        logic [15:0] m;
        logic [2:0]  o;
        int          ex, ey, ez;
        int          busy_cycles;
        int          done_seen;

        // reset then idle
        tick(); tick();
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done || busy) done_seen++;
        end
        check("idle_no_busy_done", done_seen, 0);
        check("rst_lu_in", lu_in, 0);
        check("rst_sig", sig, 0);
        check("rst_cnt", ones_cnt, 0);
        check("rst_pass", pass, 0);

        // zero stub sweep; extra start pulses mid-run and in DONE
        lu_sel = 2'd0; mode = 1'b0; exp_sig = 16'h0;
        start = 1'b1;
        tick();
        start = 1'b0;
        busy_cycles = 0;
        done_seen = 0;
        for (int c = 0; c < 64; c++) begin
            if (busy) busy_cycles++;
            if (done) done_seen++;
            if (lu_in != N_IN'(c / 2)) check("walk_lu_in", lu_in, c / 2);
            start = (c == 20 || c == 41);
            tick();
        end
        start = 1'b0;
        check("sweep_busy_cycles", busy_cycles, 64);
        check("sweep_no_early_done", done_seen, 0);
        check("sweep_done", done, 1);
        check("sweep_busy_low_in_done", busy, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("done_pulse_one_cycle", done, 0);
        check("start_in_done_ignored", busy, 0);
        tick();
        check("still_idle", busy, 0);
        check("zero_sig", sig, 0);
        check("zero_cnt", ones_cnt, 0);
        check("zero_pass", pass, 1);

        // constant x=1 stub sweep
        m = 16'h0;
        for (int i = 0; i < 32; i++) m = misr_step(m, 3'b001);
        lu_sel = 2'd1; exp_sig = m;
        run_to_done("x1_done");
        check("x1_cnt_x", fld(0), 32);
        check("x1_cnt_y", fld(1), 0);
        check("x1_cnt_z", fld(2), 0);
        check("x1_sig", sig, m);
        check("x1_pass", pass, 1);
        exp_sig = m ^ 16'h1;
        run_to_done("x1_bad_done");
        check("x1_bad_pass", pass, 0);
        check("x1_bad_sig", sig, m);

        // single vector 11111 on real unit: x=1 y=1 z=0, sig = 3
        lu_sel = 2'd2; mode = 1'b1; vec_in = 5'b11111; exp_sig = 16'h0003;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("single_lu_in", lu_in, 31);
        check("single_busy_wait", busy, 1);
        tick();
        check("single_busy_sample", busy, 1);
        check("single_no_early_done", done, 0);
        tick();
        check("single_done", done, 1);
        check("single_cnt", ones_cnt, {6'd0, 6'd1, 6'd1});
        check("single_sig", sig, 3);
        check("single_pass", pass, 1);
        tick();

        // sweep with abort in the SAMPLE cycle of vector 10
        mode = 1'b0; exp_sig = 16'h0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 21; c++) tick();
        check("abort_at_vec10", lu_in, 10);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy_low", busy, 0);
        check("abort_no_done", done, 0);
        check("abort_lu_in", lu_in, 10);
        ex = 0; ey = 0; ez = 0; m = 16'h0;
        for (int v = 0; v < 10; v++) begin
            o = lu_fn(5'(v));
            ex += o[0]; ey += o[1]; ez += o[2];
            m = misr_step(m, o);
        end
        check("abort_cnt_x", fld(0), ex);
        check("abort_cnt_y", fld(1), ey);
        check("abort_cnt_z", fld(2), ez);
        check("abort_sig", sig, m);
        check("abort_pass", pass, 0);
        done_seen = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done || busy) done_seen++;
        end
        check("abort_stays_idle", done_seen, 0);

        // abort + start together in IDLE: stay idle
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("abort_beats_start", busy, 0);

        // restart clears accumulators and begins at 0
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_lu_in", lu_in, 0);
        check("restart_sig", sig, 0);
        check("restart_cnt", ones_cnt, 0);
        check("restart_busy", busy, 1);

        // reset mid-sweep
        for (int i = 0; i < 15; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_lu_in", lu_in, 0);
        check("midrst_sig", sig, 0);
        check("midrst_cnt", ones_cnt, 0);
        check("midrst_pass", pass, 0);
        tick();
        check("midrst_no_done", done, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
